// File: rtl/decoder_pkg.sv
// Shared types and the select-to-vector decode used by decoder_onehot_pipe.
package decoder_pkg;

   typedef enum logic {DEC_ONEHOT, DEC_THERMO} dec_mode_e;

   localparam int DEC_MAX_W = 64;
   localparam int DEC_SEL_W = 32;

   typedef struct packed {
      logic                 err;
      logic [DEC_MAX_W-1:0] vec;
   } dec_res_t;

   // Bits at or above num_out are always zero; callers slice the low num_out bits.
   function automatic dec_res_t dec_vec(input logic [DEC_SEL_W-1:0] sel,
                                        input dec_mode_e mode,
                                        input logic en,
                                        input int num_out);
      dec_res_t r;
      r = '0;
      if (en) begin
         if (sel >= DEC_SEL_W'(num_out)) begin
            r.err = 1'b1;
         end else begin
            for (int i = 0; i < DEC_MAX_W; i++) begin
               if (i < num_out) begin
                  if (mode == DEC_THERMO) r.vec[i] = (DEC_SEL_W'(i) <= sel);
                  else                    r.vec[i] = (DEC_SEL_W'(i) == sel);
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Two-entry skid buffer: a main slot driving the outputs plus one overflow slot,
// with a registered ready that is low exactly while the overflow slot is occupied.
module dec_skid_buf #(
   parameter int DATA_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic              main_full_p1;
   logic              skid_full_p1;
   logic              ready_p1;
   logic [DATA_W-1:0] main_data_p1;
   logic [DATA_W-1:0] skid_data_p1;
   logic              accept;
   logic              drain;

   // Ready resets high so the first cycle after reset can already accept.
   assign in_ready  = ready_p1 & ~rst;
   assign accept    = in_valid & in_ready;
   assign drain     = main_full_p1 & out_ready;
   assign out_valid = main_full_p1;
   assign out_data  = main_full_p1 ? main_data_p1 : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_full_p1 <= 1'b0;
         skid_full_p1 <= 1'b0;
         ready_p1     <= 1'b1;
      end else if (skid_full_p1) begin
         if (drain) begin
            skid_full_p1 <= 1'b0;
            ready_p1     <= 1'b1;
         end
      end else if (accept) begin
         if (main_full_p1 && !drain) begin
            skid_full_p1 <= 1'b1;
            ready_p1     <= 1'b0;
         end else begin
            main_full_p1 <= 1'b1;
         end
      end else if (drain) begin
         main_full_p1 <= 1'b0;
      end
   end

   // Payload registers carry no reset; the full flags qualify them.
   always_ff @(posedge clk) begin
      if (skid_full_p1) begin
         if (drain) main_data_p1 <= skid_data_p1;
      end else if (accept) begin
         if (main_full_p1 && !drain) skid_data_p1 <= in_data;
         else                        main_data_p1 <= in_data;
      end
   end

endmodule

// File: rtl/decoder_onehot_pipe.sv
// Registered one-hot / thermometer decoder with valid/ready on both sides,
// out-of-range flagging and a saturating count of accepted error transactions.
module decoder_onehot_pipe
   import decoder_pkg::*;
#(
   parameter int SEL_W   = 2,
   parameter int NUM_OUT = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic               in_mode,
   input  logic               in_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_dout,
   output logic               out_err,
   output logic [CNT_W-1:0]   err_cnt
);

   localparam int PAY_W = NUM_OUT + 1;

   dec_res_t         dec_p0;
   logic [PAY_W-1:0] pay_p0;
   logic [PAY_W-1:0] pay_p1;
   logic             accept_p0;
   logic [CNT_W-1:0] err_cnt_p1;

   always_comb begin
      dec_p0 = dec_vec(DEC_SEL_W'(in_sel), dec_mode_e'(in_mode), in_en, NUM_OUT);
   end

   assign pay_p0    = {dec_p0.err, dec_p0.vec[NUM_OUT-1:0]};
   assign accept_p0 = in_valid & in_ready;

   if (NUM_OUT < DEC_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^dec_p0.vec[DEC_MAX_W-1:NUM_OUT];
   end

   // ---- stage p0 -> p1: decoded payload enters the slot pair ----
   dec_skid_buf #(
      .DATA_W(PAY_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (pay_p0),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (pay_p1)
   );

   assign out_err  = pay_p1[NUM_OUT];
   assign out_dout = pay_p1[NUM_OUT-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_p1 <= '0;
      end else if (accept_p0 && dec_p0.err && (err_cnt_p1 != '1)) begin
         err_cnt_p1 <= err_cnt_p1 + 1'b1;
      end
   end

   assign err_cnt = err_cnt_p1;

endmodule
